// File: rtl/sae_stream_ctrl.sv
// Byte-stream sequencer for the single-byte SAE core: FIFO-buffers host bytes, pulses each into the core, returns results.
// Optional SAE_STREAM_CNT_EN adds saturating done/drop counters.
module sae_stream_ctrl #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_load,
  input  logic [1:0] cfg_mode,
  input  logic [7:0] cfg_key,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [1:0] core_mode,
  output logic [7:0] core_data,
  output logic [7:0] core_key,
  output logic       core_valid,
  input  logic [7:0] core_result,
  input  logic       core_result_ready,
  input  logic       core_key_err,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       err_key,
  output logic       err_timeout,
  output logic       busy
`ifdef SAE_STREAM_CNT_EN
  ,
  output logic [15:0] cnt_done,
  output logic [15:0] cnt_drop
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [DEPTH];
  logic [1:0]    mode_q, mode_d;
  logic [7:0]    key_q, key_d;
  logic [7:0]    core_data_q, core_data_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          err_key_q, err_key_d;
  logic          err_timeout_q, err_timeout_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic empty, full, push, pop, flush;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign in_ready = !full && (state_q != S_ERR);
  assign push     = in_valid && in_ready;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    key_d         = key_q;
    core_data_d   = core_data_q;
    out_data_d    = out_data_q;
    err_key_d     = err_key_q;
    err_timeout_d = err_timeout_q;
    tmo_d         = tmo_q;
    pop           = 1'b0;
    flush         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_load && empty) begin
          mode_d = cfg_mode;
          key_d  = cfg_key;
        end else if (!empty) begin
          pop = 1'b1;
          // Mode 00 sessions just drain the FIFO without touching the core.
          if (mode_q != 2'b00) begin
            core_data_d = mem_q[rd_ptr_q];
            state_d     = S_ISSUE;
          end
        end
      end
      S_ISSUE:  state_d = S_SETTLE;
      S_SETTLE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_key_err) begin
          err_key_d = 1'b1;
          state_d   = S_ERR;
        end else if (core_result_ready) begin
          out_data_d = core_result;
          state_d    = S_HOLD;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = S_ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_HOLD: if (out_ready) state_d = S_IDLE;
      S_ERR: begin
        if (cfg_load) begin
          mode_d        = cfg_mode;
          key_d         = cfg_key;
          flush         = 1'b1;
          err_key_d     = 1'b0;
          err_timeout_d = 1'b0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + AW'(push);
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      mode_q        <= '0;
      key_q         <= '0;
      core_data_q   <= '0;
      out_data_q    <= '0;
      err_key_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      mode_q        <= mode_d;
      key_q         <= key_d;
      core_data_q   <= core_data_d;
      out_data_q    <= out_data_d;
      err_key_q     <= err_key_d;
      err_timeout_q <= err_timeout_d;
      tmo_q         <= tmo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign core_mode   = mode_q;
  assign core_key    = key_q;
  assign core_data   = core_data_q;
  assign core_valid  = (state_q == S_ISSUE);
  assign out_valid   = (state_q == S_HOLD);
  assign out_data    = out_data_q;
  assign err_key     = err_key_q;
  assign err_timeout = err_timeout_q;
  assign busy        = (state_q != S_IDLE) || !empty;

`ifdef SAE_STREAM_CNT_EN
  logic [15:0] cnt_done_q, cnt_done_d, cnt_drop_q, cnt_drop_d;
  logic        cfg_acc;
  logic [AW:0] drop_amt;
  logic [16:0] drop_sum;

  // An accepted cfg_load restarts both counts; bytes flushed by it count toward the new session.
  always_comb begin
    cfg_acc  = cfg_load && ((state_q == S_IDLE && empty) || state_q == S_ERR);
    drop_amt = '0;
    if (flush)
      drop_amt = count_q;
    else if (state_q == S_IDLE && !empty && mode_q == 2'b00)
      drop_amt = (AW+1)'(1);
    else if (state_q == S_WAIT && state_d == S_ERR)
      drop_amt = (AW+1)'(1);
    drop_sum   = (cfg_acc ? 17'd0 : {1'b0, cnt_drop_q}) + 17'(drop_amt);
    cnt_drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    cnt_done_d = cfg_acc ? 16'd0 : cnt_done_q;
    if (out_valid && out_ready && cnt_done_q != 16'hFFFF)
      cnt_done_d = cnt_done_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_done_q <= '0;
      cnt_drop_q <= '0;
    end else begin
      cnt_done_q <= cnt_done_d;
      cnt_drop_q <= cnt_drop_d;
    end
  end

  assign cnt_done = cnt_done_q;
  assign cnt_drop = cnt_drop_q;
`endif

endmodule

// File: tb/tb_sae_stream_ctrl.sv
// Randomized bench for sae_stream_ctrl with a behavioural SAE core stub and an in-order result scoreboard.
module tb_sae_stream_ctrl;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset, cfg_load, in_valid, in_ready, core_valid, core_result_ready, core_key_err;
  logic       out_valid, out_ready, err_key, err_timeout, busy;
  logic [1:0] cfg_mode, core_mode;
  logic [7:0] cfg_key, in_data, core_data, core_key, core_result, out_data;
`ifdef SAE_STREAM_CNT_EN
  logic [15:0] cnt_done, cnt_drop;
`endif

  always #5 clk = ~clk;

  sae_stream_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_mode(cfg_mode), .cfg_key(cfg_key),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .core_mode(core_mode), .core_data(core_data), .core_key(core_key), .core_valid(core_valid),
    .core_result(core_result), .core_result_ready(core_result_ready), .core_key_err(core_key_err),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .err_key(err_key), .err_timeout(err_timeout), .busy(busy)
`ifdef SAE_STREAM_CNT_EN
    , .cnt_done(cnt_done), .cnt_drop(cnt_drop)
`endif
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] iss_q[$];
  logic [1:0] m_mode = 2'b00;
  logic [7:0] m_key  = 8'h00;
  int         rdy_mode = 2;
  bit         stall = 1'b0;
  int         cv_count = 0;
  int         out_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Core behaviour: keygen 223-key; encrypt sum mod 256 folded below 223; decrypt plain sum mod 256.
  function automatic logic [7:0] core_fn(input logic [1:0] m, input logic [7:0] k, input logic [7:0] d);
    logic [7:0] s;
    s = d + k;
    case (m)
      2'b01:   return 8'd223 - k;
      2'b10:   return (s >= 8'd223) ? 8'(s - 8'd223) : s;
      2'b11:   return s;
      default: return d;
    endcase
  endfunction

  // Core stub: result_ready stays high (stale) through SETTLE, drops in WAIT until latency expires.
  initial begin
    bit         active = 1'b0;
    int         k = 0;
    int         lat = 2;
    logic [7:0] pend = 8'h00;
    logic       prev_cv = 1'b0;
    core_result = 8'h00; core_result_ready = 1'b0; core_key_err = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        core_result_ready = 1'b0; core_key_err = 1'b0; active = 1'b0; prev_cv = 1'b0;
      end else begin
        if (core_valid) begin
          check("cv_pulse", 32'(prev_cv), 0);
          cv_count++;
          if (iss_q.size() == 0) check("issue_unexp", 32'(core_valid), 0);
          else check("core_data", 32'(core_data), 32'(iss_q.pop_front()));
          check("core_mode", 32'(core_mode), 32'(m_mode));
          check("core_key", 32'(core_key), 32'(m_key));
          pend = core_fn(core_mode, core_key, core_data);
          lat = $urandom_range(2, 7);
          k = 0; active = 1'b1; core_key_err = 1'b0;
        end else if (active) begin
          k++;
          if (k >= 2) begin
            if (stall) core_result_ready = 1'b0;
            else if (core_mode != 2'b00 && core_key >= 8'd223) begin
              core_key_err = 1'b1; core_result_ready = 1'b0; active = 1'b0;
            end else if (k >= lat) begin
              core_result = pend; core_result_ready = 1'b1; active = 1'b0;
            end else core_result_ready = 1'b0;
          end
        end
        prev_cv = core_valid;
      end
    end
  end

  // Downstream sink and scoreboard.
  initial begin
    logic       hold_prev = 1'b0;
    logic [7:0] hold_dat = 8'h00;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      if (reset) hold_prev = 1'b0;
      else begin
        if (hold_prev) begin
          check("hold_vld", 32'(out_valid), 1);
          check("hold_stable", 32'(out_data), 32'(hold_dat));
        end
        if (out_valid && out_ready) begin
          out_count++;
          if (exp_q.size() == 0) check("out_unexp", 32'(out_valid), 0);
          else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
        hold_prev = out_valid && !out_ready;
        hold_dat  = out_data;
      end
    end
  end

  task automatic reset_dut();
    reset = 1'b1; in_valid = 1'b0; cfg_load = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete(); iss_q.delete();
    m_mode = 2'b00; m_key = 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1; in_data = b;
    while (!in_ready && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) check("push_timeout", 32'(in_ready), 1);
    else if (m_mode != 2'b00) begin
      iss_q.push_back(b);
      if (m_key < 8'd223 && !stall) exp_q.push_back(core_fn(m_mode, m_key, b));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] m, input logic [7:0] k);
    int n = 0;
    while (busy && !(err_key || err_timeout) && n < 3000) begin @(negedge clk); n++; end
    cfg_load = 1'b1; cfg_mode = m; cfg_key = k;
    @(negedge clk);
    cfg_load = 1'b0;
    m_mode = m; m_key = k;
    exp_q.delete(); iss_q.delete();
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin @(negedge clk); n++; end
    check("drain_timeout", 32'(n < 3000), 1);
  endtask

  initial begin
    int n, c, base_cv, base_out;
    reset = 1'b1; cfg_load = 1'b0; cfg_mode = 2'b00; cfg_key = 8'h00;
    in_valid = 1'b0; in_data = 8'h00;
    reset_dut();

    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_core_valid", 32'(core_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err_key", 32'(err_key), 0);
    check("rst_err_tmo", 32'(err_timeout), 0);
    check("rst_core_mode", 32'(core_mode), 0);
    check("rst_core_key", 32'(core_key), 0);
    check("rst_out_data", 32'(out_data), 0);

    // Mode 00 after reset: bytes drain with no core traffic.
    base_cv = cv_count;
    for (int i = 0; i < 5; i++) push(8'($urandom));
    wait_drain();
    check("m0_no_core", 32'(cv_count - base_cv), 0);
`ifdef SAE_STREAM_CNT_EN
    check("m0_cnt_drop", 32'(cnt_drop), 5);
    check("m0_cnt_done", 32'(cnt_done), 0);
`endif

    // Keygen with the sink stalled: result must be held.
    cfg(2'b01, 8'h20);
    rdy_mode = 0;
    push(8'h00);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    check("kg_hold_vld", 32'(out_valid), 1);
    check("kg_data", 32'(out_data), 32'hBF);
    check("kg_err_key", 32'(err_key), 0);
    rdy_mode = 2;
    wait_drain();

    // Encrypt, including the fold of sums at or above 223.
    cfg(2'b10, 8'h40);
    rdy_mode = 1;
    push(8'h10); push(8'hA0); push(8'hC8);
    wait_drain();
`ifdef SAE_STREAM_CNT_EN
    check("enc_cnt_done", 32'(cnt_done), 3);
`endif

    // Random sessions with random gaps and sink backpressure.
    for (int s = 0; s < 4; s++) begin
      cfg(2'($urandom_range(1, 3)), 8'($urandom_range(0, 222)));
      for (int i = 0; i < 12; i++) begin
        push(8'($urandom));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_drain();
    end

    // Backpressure: one byte in the core plus DEPTH buffered fills the block.
    cfg(2'b10, 8'h33);
    rdy_mode = 0;
    base_out = out_count;
    for (int i = 0; i < DEPTH + 1; i++) push(8'(i * 17 + 3));
    repeat (30) @(negedge clk);
    check("bp_in_ready", 32'(in_ready), 0);
    check("bp_busy", 32'(busy), 1);
    rdy_mode = 1;
    push(8'hEE);
    wait_drain();
    check("bp_count", 32'(out_count - base_out), DEPTH + 2);

    // Invalid key: ERR, then recovery through cfg_load.
    rdy_mode = 2;
    cfg(2'b11, 8'hDF);
    base_out = out_count;
    push(8'h55);
    n = 0;
    while (!err_key && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    check("ke_err_key", 32'(err_key), 1);
    check("ke_in_ready", 32'(in_ready), 0);
    check("ke_busy", 32'(busy), 1);
    check("ke_err_tmo", 32'(err_timeout), 0);
    check("ke_no_out", 32'(out_count - base_out), 0);
    cfg(2'b11, 8'h05);
    check("ke_clr_err", 32'(err_key), 0);
    check("ke_clr_busy", 32'(busy), 0);
    check("ke_clr_in_ready", 32'(in_ready), 1);
    push(8'h55);
    wait_drain();
    check("ke_recover_out", 32'(out_count - base_out), 1);

    // Timeout: core never answers.
    stall = 1'b1;
    cfg(2'b10, 8'h11);
    push(8'h42);
    n = 0;
    while (!core_valid && n < 100) begin @(negedge clk); n++; end
    c = 0;
    while (!err_timeout && c < 200) begin @(negedge clk); c++; end
    check("tmo_cycles", 32'(c), TIMEOUT + 2);
    check("tmo_in_ready", 32'(in_ready), 0);
    check("tmo_err_key", 32'(err_key), 0);
    reset_dut();
    check("tmo_rst_clr", 32'(err_timeout), 0);

    // Reset landing in WAIT.
    cfg(2'b10, 8'h11);
    push(8'h24);
    n = 0;
    while (!core_valid && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_core_valid", 32'(core_valid), 0);
    check("mrst_out_valid", 32'(out_valid), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_in_ready", 32'(in_ready), 1);
    check("mrst_core_mode", 32'(core_mode), 0);
    check("mrst_core_data", 32'(core_data), 0);
    reset_dut();
    stall = 1'b0;
    base_out = out_count;
    repeat (30) @(negedge clk);
    check("mrst_no_out", 32'(out_count - base_out), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0x0 expected 0x1");
    $fatal(1, "bench time limit reached");
  end
endmodule
